// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_e;

  localparam logic [3:0] REG_ZERO = 4'h0;

  // HLT needs this many cycles after leaving ID to retire in WB.
  localparam int DRAIN_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear wins over increment; the increment is dropped once saturated.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: sequences pipeline-register enables and
// flushes for load-use stalls, taken branches, memory wait states and the
// halt drain, and keeps saturating stall-cycle counters for debug.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | normal issue; dmem > load-use > branch > halt > imem priority
// DRAIN  | HLT is in flight toward WB; fetch is held, IF/ID is flushed
// HALTED | HLT retired; every stage frozen until reset
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDEX_MemRead,
  input  logic [3:0]       IDEX_RegisterRd,
  input  logic [3:0]       IFID_RegisterRs,
  input  logic [3:0]       IFID_RegisterRt,
  input  logic             IFID_UsesRt,
  input  logic             IFID_IsStore,
  input  logic             Branch_Taken,
  input  logic             Halt_ID,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Write,
  output logic             IDEX_Bubble,
  output logic             EXMEM_Write,
  output logic             MEMWB_Bubble,
  output logic             Halted,
  output logic [CNT_W-1:0] LdUseCnt,
  output logic [CNT_W-1:0] MemWaitCnt
);

  localparam int DW = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  pipe_state_e   state;
  pipe_state_e   nextState;
  logic [DW-1:0] drainCnt;
  logic [DW-1:0] nextDrainCnt;
  logic          ldu;
  logic          rsMatch;
  logic          rtMatch;
  logic          ldUseInc;
  logic          memWaitInc;

  // Load-use detect. A store's Rt is its data operand, which MEM-MEM
  // forwarding covers, so it never stalls on a preceding load.
  always_comb begin
    rsMatch = (IDEX_RegisterRd == IFID_RegisterRs);
    rtMatch = IFID_UsesRt && !IFID_IsStore && (IDEX_RegisterRd == IFID_RegisterRt);
    ldu     = IDEX_MemRead && (IDEX_RegisterRd != REG_ZERO) && (rsMatch || rtMatch);
  end

  // State, drain timer and the Halted flag; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      drainCnt <= '0;
      Halted   <= 1'b0;
    end else begin
      state    <= nextState;
      drainCnt <= nextDrainCnt;
      Halted   <= (nextState == HALTED);
    end
  end

  // Next-state and combinational enables; reset forces a safe NOP pattern.
  always_comb begin
    nextState    = state;
    nextDrainCnt = drainCnt;
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Write   = 1'b1;
    IDEX_Bubble  = 1'b0;
    EXMEM_Write  = 1'b1;
    MEMWB_Bubble = 1'b0;
    ldUseInc     = 1'b0;
    memWaitInc   = 1'b0;

    unique case (state)
      RUN: begin
        if (dmem_stall) begin
          PC_Write     = 1'b0;
          IFID_Write   = 1'b0;
          IDEX_Write   = 1'b0;
          EXMEM_Write  = 1'b0;
          MEMWB_Bubble = 1'b1;
          memWaitInc   = 1'b1;
        end else if (ldu) begin
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
          ldUseInc    = 1'b1;
        end else if (Branch_Taken) begin
          IFID_Flush = 1'b1;
        end else if (Halt_ID) begin
          PC_Write     = 1'b0;
          IFID_Flush   = 1'b1;
          nextState    = DRAIN;
          nextDrainCnt = DRAIN_LOAD;
        end else if (imem_stall) begin
          PC_Write   = 1'b0;
          IFID_Flush = 1'b1;
        end
      end

      DRAIN: begin
        PC_Write   = 1'b0;
        IFID_Flush = 1'b1;
        if (dmem_stall) begin
          IFID_Write   = 1'b0;
          IDEX_Write   = 1'b0;
          EXMEM_Write  = 1'b0;
          MEMWB_Bubble = 1'b1;
          memWaitInc   = 1'b1;
        end else if (drainCnt == '0) begin
          nextState = HALTED;
        end else begin
          nextDrainCnt = drainCnt - DW'(1);
        end
      end

      HALTED: begin
        PC_Write     = 1'b0;
        IFID_Write   = 1'b0;
        IDEX_Write   = 1'b0;
        EXMEM_Write  = 1'b0;
        IFID_Flush   = 1'b1;
        IDEX_Bubble  = 1'b1;
        MEMWB_Bubble = 1'b1;
      end

      default: begin
        nextState = RUN;
      end
    endcase

    if (rst) begin
      PC_Write     = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Write   = 1'b1;
      EXMEM_Write  = 1'b1;
      IFID_Flush   = 1'b1;
      IDEX_Bubble  = 1'b1;
      MEMWB_Bubble = 1'b1;
      ldUseInc     = 1'b0;
      memWaitInc   = 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) ldUseCounter (
    .clk   (clk),
    .clr   (rst),
    .inc   (ldUseInc),
    .count (LdUseCnt)
  );

  sat_counter #(.W(CNT_W)) memWaitCounter (
    .clk   (clk),
    .clr   (rst),
    .inc   (memWaitInc),
    .count (MemWaitCnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed check of hazard_ctrl against a cycle-level
// behavioural model; a second instance with 2-bit counters shows saturation.
module tb_hazard_ctrl;

  localparam int DRAIN = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       IDEX_MemRead;
  logic [3:0] IDEX_RegisterRd;
  logic [3:0] IFID_RegisterRs;
  logic [3:0] IFID_RegisterRt;
  logic       IFID_UsesRt;
  logic       IFID_IsStore;
  logic       Branch_Taken;
  logic       Halt_ID;
  logic       imem_stall;
  logic       dmem_stall;

  logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble;
  logic        EXMEM_Write, MEMWB_Bubble, Halted;
  logic [15:0] LdUseCnt, MemWaitCnt;

  logic        PC_Write2, IFID_Write2, IFID_Flush2, IDEX_Write2, IDEX_Bubble2;
  logic        EXMEM_Write2, MEMWB_Bubble2, Halted2;
  logic [1:0]  LdUseCnt2, MemWaitCnt2;

  int vectors = 0;
  int miscompares = 0;

  // model state: halt progress and counter totals
  bit mHalted;
  bit mDraining;
  int mDrainLeft;
  int mLdu, mMw;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RegisterRd(IDEX_RegisterRd),
    .IFID_RegisterRs(IFID_RegisterRs), .IFID_RegisterRt(IFID_RegisterRt),
    .IFID_UsesRt(IFID_UsesRt), .IFID_IsStore(IFID_IsStore),
    .Branch_Taken(Branch_Taken), .Halt_ID(Halt_ID),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Write(IDEX_Write), .IDEX_Bubble(IDEX_Bubble),
    .EXMEM_Write(EXMEM_Write), .MEMWB_Bubble(MEMWB_Bubble),
    .Halted(Halted), .LdUseCnt(LdUseCnt), .MemWaitCnt(MemWaitCnt)
  );

  hazard_ctrl #(.CNT_W(2), .DRAIN_CYCLES(DRAIN)) dut2 (
    .clk(clk), .rst(rst),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RegisterRd(IDEX_RegisterRd),
    .IFID_RegisterRs(IFID_RegisterRs), .IFID_RegisterRt(IFID_RegisterRt),
    .IFID_UsesRt(IFID_UsesRt), .IFID_IsStore(IFID_IsStore),
    .Branch_Taken(Branch_Taken), .Halt_ID(Halt_ID),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .PC_Write(PC_Write2), .IFID_Write(IFID_Write2), .IFID_Flush(IFID_Flush2),
    .IDEX_Write(IDEX_Write2), .IDEX_Bubble(IDEX_Bubble2),
    .EXMEM_Write(EXMEM_Write2), .MEMWB_Bubble(MEMWB_Bubble2),
    .Halted(Halted2), .LdUseCnt(LdUseCnt2), .MemWaitCnt(MemWaitCnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit loadUse();
    if (!IDEX_MemRead || IDEX_RegisterRd == 4'd0) return 1'b0;
    if (IDEX_RegisterRd == IFID_RegisterRs) return 1'b1;
    return IFID_UsesRt && !IFID_IsStore && (IDEX_RegisterRd == IFID_RegisterRt);
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic quiet();
    rst = 1'b0; IDEX_MemRead = 1'b0; IDEX_RegisterRd = 4'd0;
    IFID_RegisterRs = 4'd0; IFID_RegisterRt = 4'd0; IFID_UsesRt = 1'b0;
    IFID_IsStore = 1'b0; Branch_Taken = 1'b0; Halt_ID = 1'b0;
    imem_stall = 1'b0; dmem_stall = 1'b0;
  endtask

  // Called just after a falling edge with inputs applied: checks this
  // cycle's outputs, then advances the model across the rising edge.
  task automatic tick();
    bit hz;
    bit ePc, eIfw, eIff, eIdw, eIdb, eExw, eMwb;
    #1;
    hz = loadUse();
    ePc = 1; eIfw = 1; eIff = 0; eIdw = 1; eIdb = 0; eExw = 1; eMwb = 0;
    if (rst) begin
      ePc = 0; eIfw = 0; eIff = 1; eIdb = 1; eMwb = 1;
    end else if (mHalted) begin
      ePc = 0; eIfw = 0; eIdw = 0; eExw = 0; eIff = 1; eIdb = 1; eMwb = 1;
    end else if (mDraining) begin
      ePc = 0; eIff = 1;
      if (dmem_stall) begin eIfw = 0; eIdw = 0; eExw = 0; eMwb = 1; end
    end else if (dmem_stall) begin
      ePc = 0; eIfw = 0; eIdw = 0; eExw = 0; eMwb = 1;
    end else if (hz) begin
      ePc = 0; eIfw = 0; eIdb = 1;
    end else if (Branch_Taken) begin
      eIff = 1;
    end else if (Halt_ID || imem_stall) begin
      ePc = 0; eIff = 1;
    end
    chk("PC_Write", PC_Write, ePc);
    chk("IFID_Write", IFID_Write, eIfw);
    chk("IFID_Flush", IFID_Flush, eIff);
    chk("IDEX_Write", IDEX_Write, eIdw);
    chk("IDEX_Bubble", IDEX_Bubble, eIdb);
    chk("EXMEM_Write", EXMEM_Write, eExw);
    chk("MEMWB_Bubble", MEMWB_Bubble, eMwb);
    chk("Halted", Halted, mHalted);
    chk("LdUseCnt", LdUseCnt, sat(mLdu, 65535));
    chk("MemWaitCnt", MemWaitCnt, sat(mMw, 65535));
    chk("LdUseCnt2", LdUseCnt2, sat(mLdu, 3));
    chk("MemWaitCnt2", MemWaitCnt2, sat(mMw, 3));
    @(posedge clk);
    if (rst) begin
      mHalted = 0; mDraining = 0; mDrainLeft = 0; mLdu = 0; mMw = 0;
    end else if (mHalted) begin
      // frozen until reset
    end else if (mDraining) begin
      if (dmem_stall) mMw++;
      else if (mDrainLeft == 0) begin mDraining = 0; mHalted = 1; end
      else mDrainLeft--;
    end else if (dmem_stall) begin
      mMw++;
    end else if (hz) begin
      mLdu++;
    end else if (!Branch_Taken && Halt_ID) begin
      mDraining = 1; mDrainLeft = DRAIN - 1;
    end
    @(negedge clk);
  endtask

  initial begin
    mHalted = 0; mDraining = 0; mDrainLeft = 0; mLdu = 0; mMw = 0;
    quiet();
    rst = 1'b1;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    // load-use via Rs, then the Rd=0 case that must not stall
    IDEX_MemRead = 1; IDEX_RegisterRd = 4'd5; IFID_RegisterRs = 4'd5;
    tick();
    quiet(); tick();
    chk("ldu_count_one", LdUseCnt, 1);
    IDEX_MemRead = 1; IDEX_RegisterRd = 4'd0; IFID_RegisterRs = 4'd0;
    tick();

    // load feeding store data: no stall; same regs as non-store ALU op: stall
    quiet();
    IDEX_MemRead = 1; IDEX_RegisterRd = 4'd3; IFID_RegisterRt = 4'd3;
    IFID_RegisterRs = 4'd7; IFID_UsesRt = 1; IFID_IsStore = 1;
    tick();
    IFID_IsStore = 0;
    tick();
    chk("ldu_count_rt", LdUseCnt, 2);

    // branch masked by load-use, then taken on its own
    quiet();
    IDEX_MemRead = 1; IDEX_RegisterRd = 4'd2; IFID_RegisterRs = 4'd2; Branch_Taken = 1;
    tick();
    IDEX_MemRead = 0;
    tick();
    quiet(); tick();

    // halt with two memory wait cycles inside the drain
    Halt_ID = 1; tick();
    Halt_ID = 0; dmem_stall = 1; tick(); tick();
    dmem_stall = 0; tick(); tick();
    chk("halted_not_yet", Halted, 0);
    tick();
    chk("halted_after_5", Halted, 1);
    chk("memwait_two", MemWaitCnt, 2);
    Branch_Taken = 1; imem_stall = 1; tick(); tick();
    chk("halted_sticky", Halted, 1);

    // reset, then six memory wait cycles: 2-bit counter saturates at 3
    quiet(); rst = 1; tick();
    rst = 0; dmem_stall = 1;
    repeat (6) tick();
    chk("memwait_sat", MemWaitCnt2, 3);
    chk("memwait_full", MemWaitCnt, 6);

    // reset in the middle of a drain
    quiet(); Halt_ID = 1; tick();
    Halt_ID = 0; tick();
    rst = 1; tick();
    rst = 0; tick(); tick(); tick(); tick();
    chk("rst_mid_drain", Halted, 0);

    // random traffic with narrow register fields for frequent hazards
    for (int i = 0; i < 800; i++) begin
      rst             = ($urandom_range(0, 39) == 0);
      IDEX_MemRead    = 1'($urandom_range(0, 1));
      IDEX_RegisterRd = 4'($urandom_range(0, 3));
      IFID_RegisterRs = 4'($urandom_range(0, 3));
      IFID_RegisterRt = 4'($urandom_range(0, 3));
      IFID_UsesRt     = 1'($urandom_range(0, 1));
      IFID_IsStore    = 1'($urandom_range(0, 1));
      Branch_Taken    = ($urandom_range(0, 5) == 0);
      Halt_ID         = ($urandom_range(0, 11) == 0);
      imem_stall      = ($urandom_range(0, 3) == 0);
      dmem_stall      = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
